dma_burst_splitter: RTL



---
 rtl/dma_burst_splitter.sv | 118 +++++++++++
 1 files changed

// File: rtl/dma_burst_splitter.sv
// Splits whole DMA transfers into AXI-legal bursts capped at MaxBeats and never crossing a page.
// Burst outputs come only from registers; the next transfer is taken once the last burst leaves.
module dma_burst_splitter #(
    parameter int AddrWidth    = 32,
    parameter int DataWidth    = 64,
    parameter int BeatCntWidth = 32,
    parameter int IdWidth      = 4,
    parameter int MaxBeats     = 256,
    parameter int PageBytes    = 4096
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [AddrWidth-1:0]    req_addr_i,
    input  logic [BeatCntWidth-1:0] req_beats_i,
    input  logic [IdWidth-1:0]      req_id_i,
    input  logic                    req_valid_i,
    output logic                    req_ready_o,
    output logic [AddrWidth-1:0]    burst_addr_o,
    output logic [7:0]              burst_len_o,
    output logic [IdWidth-1:0]      burst_id_o,
    output logic                    burst_last_o,
    output logic                    burst_valid_o,
    input  logic                    burst_ready_i,
    output logic                    busy_o
);

    localparam int BeatBytes = DataWidth / 8;
    localparam int OffW      = $clog2(BeatBytes);
    // One bit wider than either operand so the page distance and beat count compare without overflow.
    localparam int CmpW      = (BeatCntWidth > AddrWidth) ? BeatCntWidth + 1 : AddrWidth + 1;
    localparam logic [AddrWidth-1:0] PageMask = AddrWidth'(PageBytes - 1);
    localparam logic [AddrWidth-1:0] BeatMask = AddrWidth'(BeatBytes - 1);

    typedef enum logic {
        IDLE,
        SPLIT
    } state_e;

    state_e                  state_q, state_d;
    logic [AddrWidth-1:0]    cur_addr_q, cur_addr_d;
    logic [BeatCntWidth-1:0] remaining_q, remaining_d;
    logic [IdWidth-1:0]      cur_id_q, cur_id_d;

    logic [AddrWidth-1:0]    page_off;
    logic [CmpW-1:0]         to_page;
    logic [CmpW-1:0]         rem_ext;
    logic [CmpW-1:0]         chunk;
    logic                    is_last;
    logic                    in_split;

    assign page_off = cur_addr_q & PageMask;
    assign rem_ext  = CmpW'(remaining_q);
    assign in_split = (state_q == SPLIT);

    always_comb begin
        to_page = (CmpW'(PageBytes) - CmpW'(page_off)) >> OffW;
        chunk   = rem_ext;
        if (CmpW'(MaxBeats) < chunk) begin
            chunk = CmpW'(MaxBeats);
        end
        if (to_page < chunk) begin
            chunk = to_page;
        end
    end

    assign is_last = (rem_ext == chunk);

    // Burst fields are forced to zero outside SPLIT so the idle bus is quiet.
    assign req_ready_o   = !in_split;
    assign busy_o        = in_split;
    assign burst_valid_o = in_split;
    assign burst_addr_o  = in_split ? cur_addr_q : '0;
    assign burst_len_o   = in_split ? 8'(chunk - CmpW'(1)) : 8'd0;
    assign burst_id_o    = in_split ? cur_id_q : '0;
    assign burst_last_o  = in_split && is_last;

    always_comb begin
        state_d     = state_q;
        cur_addr_d  = cur_addr_q;
        remaining_d = remaining_q;
        cur_id_d    = cur_id_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid_i && (req_beats_i != '0)) begin
                    cur_addr_d  = req_addr_i & ~BeatMask;
                    remaining_d = req_beats_i;
                    cur_id_d    = req_id_i;
                    state_d     = SPLIT;
                end
            end
            SPLIT: begin
                if (burst_ready_i) begin
                    cur_addr_d  = cur_addr_q + (AddrWidth'(chunk) << OffW);
                    remaining_d = remaining_q - BeatCntWidth'(chunk);
                    if (is_last) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            cur_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            cur_addr_q  <= cur_addr_d;
            remaining_q <= remaining_d;
            cur_id_q    <= cur_id_d;
        end
    end

endmodule
